// File: rtl/multdiv_seq_pkg.sv
// multdiv_pkg: shared encodings for the iterative multiply/divide unit.
//   OP_MULT/OP_DIV/OP_REM : latched operation code
//   state_t               : sequencer state encoding
//   cnt_width()           : width of the iteration down-counter for a given WIDTH
package multdiv_pkg;

    localparam logic [1:0] OP_MULT = 2'd0;
    localparam logic [1:0] OP_DIV  = 2'd1;
    localparam logic [1:0] OP_REM  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/multdiv_seq_if.sv
// multdiv_seq_if: operand/control/result bundle between the execute stage and
// the multiply/divide unit.
//   data_operandA/B      : operands, sampled on a start cycle
//   ctrl_MULT/DIV/REM    : start pulses
//   data_result          : result, held until the next completed operation
//   data_exception       : overflow / divide-by-zero flag, held with the result
//   data_resultRDY       : one-cycle completion pulse
//   data_busy            : operation in flight
// master = requester (execute stage), slave = multdiv_seq.
interface multdiv_seq_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic             ctrl_MULT;
    logic             ctrl_DIV;
    logic             ctrl_REM;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;
    logic             data_busy;

    modport master (
        output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV, ctrl_REM,
        input  data_result, data_exception, data_resultRDY, data_busy
    );

    modport slave (
        input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV, ctrl_REM,
        output data_result, data_exception, data_resultRDY, data_busy
    );
endinterface

// File: rtl/multdiv_seq_iter_step.sv
// multdiv_iter_step: one combinational iteration of the multiply/divide datapath.
//   acc, part  : accumulator and partial register (together a 2*WIDTH shift pair)
//   opnd       : operand magnitude (multiplicand for MULT, divisor for DIV/REM)
//   op         : latched operation code
//   acc_next, part_next : register values after this iteration
// MULT: right-shifting shift-add, multiplier consumed from part[0], product
//       accumulates as {acc, part}.
// DIV/REM: restoring division, dividend shifted out of part's MSB into acc,
//       quotient bits shifted into part's LSB, remainder left in acc.
module multdiv_iter_step
    import multdiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] part,
    input  logic [WIDTH-1:0] opnd,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] acc_next,
    output logic [WIDTH-1:0] part_next
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;

    assign sum     = {1'b0, acc} + (part[0] ? {1'b0, opnd} : '0);
    assign shifted = {acc, part[WIDTH-1]};
    // Only used when shifted >= opnd, so the true difference is < opnd and fits WIDTH bits.
    assign diff    = shifted[WIDTH-1:0] - opnd;

    always_comb begin
        acc_next  = acc;
        part_next = part;
        if (op == OP_MULT) begin
            acc_next  = sum[WIDTH:1];
            part_next = {sum[0], part[WIDTH-1:1]};
        end else if (shifted >= {1'b0, opnd}) begin
            acc_next  = diff;
            part_next = {part[WIDTH-2:0], 1'b1};
        end else begin
            acc_next  = shifted[WIDTH-1:0];
            part_next = {part[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/multdiv_seq.sv
// multdiv_seq: parametrised iterative multiply / divide / remainder unit.
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : multdiv_seq_if slave (operands, start pulses, result/flags)
// Operations work on operand magnitudes; signs are restored in the FIX cycle.
// A start pulse in any state aborts the current operation and restarts.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | no operation in flight; result registers hold last result
// S_RUN  | WIDTH iteration edges, counter counts WIDTH down to 1
// S_FIX  | sign correction, result/exception registered, RDY raised
module multdiv_seq
    import multdiv_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int SIGNED = 1
) (
    input logic           clock,
    input logic           reset_n,
    multdiv_seq_if.slave  bus
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

    state_t state, next_state;
    logic [CW-1:0] cnt;

    logic [1:0]       op_q;
    logic [WIDTH-1:0] acc, part, opnd;
    logic [WIDTH-1:0] acc_next, part_next;
    logic             neg_q, a_neg_q, b_zero_q, ovf_q;

    logic [WIDTH-1:0] result_q;
    logic             exc_q, rdy_q;

    logic             start, step_en, fix_en;
    logic [1:0]       op_sel;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] mag_a, mag_b;

    logic [2*WIDTH-1:0] prod_mag, prod;
    logic [WIDTH-1:0]   fix_res;
    logic               fix_exc;

    assign start = bus.ctrl_MULT | bus.ctrl_DIV | bus.ctrl_REM;

    always_comb begin
        op_sel = OP_REM;
        if (bus.ctrl_MULT)     op_sel = OP_MULT;
        else if (bus.ctrl_DIV) op_sel = OP_DIV;
    end

    assign a_neg = (SIGNED != 0) && bus.data_operandA[WIDTH-1];
    assign b_neg = (SIGNED != 0) && bus.data_operandB[WIDTH-1];
    // MIN_INT negates to itself, which is its correct unsigned magnitude.
    assign mag_a = a_neg ? -bus.data_operandA : bus.data_operandA;
    assign mag_b = b_neg ? -bus.data_operandB : bus.data_operandB;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        step_en    = 1'b0;
        fix_en     = 1'b0;
        if (start) begin
            next_state = S_RUN;
        end else begin
            case (state)
                S_RUN: begin
                    step_en = 1'b1;
                    if (cnt == CW'(1)) next_state = S_FIX;
                end
                S_FIX: begin
                    fix_en     = 1'b1;
                    next_state = S_IDLE;
                end
                default: next_state = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)     cnt <= '0;
        else if (start)   cnt <= CW'(WIDTH);
        else if (step_en) cnt <= cnt - CW'(1);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            op_q     <= OP_MULT;
            acc      <= '0;
            part     <= '0;
            opnd     <= '0;
            neg_q    <= 1'b0;
            a_neg_q  <= 1'b0;
            b_zero_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (start) begin
            op_q     <= op_sel;
            acc      <= '0;
            part     <= (op_sel == OP_MULT) ? mag_b : mag_a;
            opnd     <= (op_sel == OP_MULT) ? mag_a : mag_b;
            neg_q    <= a_neg ^ b_neg;
            a_neg_q  <= a_neg;
            b_zero_q <= (bus.data_operandB == '0);
            ovf_q    <= (SIGNED != 0) && (bus.data_operandA == MIN_INT)
                        && (bus.data_operandB == '1);
        end else if (step_en) begin
            acc  <= acc_next;
            part <= part_next;
        end
    end

    multdiv_iter_step #(.WIDTH(WIDTH)) u_step (
        .acc       (acc),
        .part      (part),
        .opnd      (opnd),
        .op        (op_q),
        .acc_next  (acc_next),
        .part_next (part_next)
    );

    assign prod_mag = {acc, part};
    assign prod     = neg_q ? -prod_mag : prod_mag;

    always_comb begin
        fix_res = '0;
        fix_exc = 1'b0;
        case (op_q)
            OP_MULT: begin
                fix_res = prod[WIDTH-1:0];
                if (SIGNED != 0)
                    fix_exc = !((&prod[2*WIDTH-1:WIDTH-1]) || !(|prod[2*WIDTH-1:WIDTH-1]));
                else
                    fix_exc = |prod[2*WIDTH-1:WIDTH];
            end
            OP_DIV: begin
                if (b_zero_q) begin
                    fix_exc = 1'b1;
                end else begin
                    // MIN_INT / -1 yields quotient magnitude MIN_INT, which negates back to MIN_INT.
                    fix_res = neg_q ? -part : part;
                    fix_exc = ovf_q;
                end
            end
            default: begin
                if (b_zero_q) fix_exc = 1'b1;
                else          fix_res = a_neg_q ? -acc : acc;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            result_q <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            rdy_q <= fix_en;
            if (fix_en) begin
                result_q <= fix_res;
                exc_q    <= fix_exc;
            end
        end
    end

    assign bus.data_result    = result_q;
    assign bus.data_exception = exc_q;
    assign bus.data_resultRDY = rdy_q;
    assign bus.data_busy      = (state != S_IDLE);

endmodule

// File: tb/tb_multdiv_seq.sv
module tb_multdiv_seq;
    import multdiv_pkg::*;

    typedef struct {
        bit          w8;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        exc;
    } vec_t;

    logic clock = 1'b0;
    logic reset_n;
    int   total = 0;
    int   bad   = 0;
    vec_t vecs[$];

    always #5 clock = ~clock;

    multdiv_seq_if #(.WIDTH(32)) b32 ();
    multdiv_seq_if #(.WIDTH(8))  b8 ();

    multdiv_seq #(.WIDTH(32), .SIGNED(1)) dut32 (.clock(clock), .reset_n(reset_n), .bus(b32));
    multdiv_seq #(.WIDTH(8),  .SIGNED(0)) dut8  (.clock(clock), .reset_n(reset_n), .bus(b8));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit w8, input bit m, input bit d, input bit r,
                         input logic [31:0] a, input logic [31:0] b);
        if (w8) begin
            b8.ctrl_MULT = m; b8.ctrl_DIV = d; b8.ctrl_REM = r;
            b8.data_operandA = a[7:0]; b8.data_operandB = b[7:0];
        end else begin
            b32.ctrl_MULT = m; b32.ctrl_DIV = d; b32.ctrl_REM = r;
            b32.data_operandA = a; b32.data_operandB = b;
        end
    endtask

    function automatic logic [31:0] get_res(input bit w8);
        return w8 ? {24'h0, b8.data_result} : b32.data_result;
    endfunction
    function automatic logic get_exc(input bit w8);
        return w8 ? b8.data_exception : b32.data_exception;
    endfunction
    function automatic logic get_rdy(input bit w8);
        return w8 ? b8.data_resultRDY : b32.data_resultRDY;
    endfunction
    function automatic logic get_busy(input bit w8);
        return w8 ? b8.data_busy : b32.data_busy;
    endfunction

    // Called at the negedge right after the start edge; n counts edges after it.
    task automatic wait_rdy(input bit w8, input int max, output int lat,
                            output logic [31:0] res, output logic exc, output bit busy_bad);
        lat = 0; res = '0; exc = 1'b0; busy_bad = 1'b0;
        for (int n = 1; n <= max; n++) begin
            @(posedge clock); @(negedge clock);
            if (get_rdy(w8)) begin
                lat = n; res = get_res(w8); exc = get_exc(w8);
                if (get_busy(w8)) busy_bad = 1'b1;
                break;
            end else if (!get_busy(w8)) begin
                busy_bad = 1'b1;
            end
        end
    endtask

    task automatic start_op(input bit w8, input bit m, input bit d, input bit r,
                            input logic [31:0] a, input logic [31:0] b);
        drive(w8, m, d, r, a, b);
        @(posedge clock); @(negedge clock);
        drive(w8, 1'b0, 1'b0, 1'b0, $urandom, $urandom);
    endtask

    task automatic run_check(input string name, input bit w8, input bit m, input bit d,
                             input bit r, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] exp_res, input logic exp_exc);
        int lat; logic [31:0] res; logic exc; bit busy_bad;
        start_op(w8, m, d, r, a, b);
        wait_rdy(w8, 60, lat, res, exc, busy_bad);
        check({name, " latency"}, lat, w8 ? 32'd9 : 32'd33);
        check({name, " result"}, res, exp_res);
        check({name, " exc"}, {31'h0, exc}, {31'h0, exp_exc});
        check({name, " busy"}, {31'h0, busy_bad}, 32'h0);
        @(posedge clock); @(negedge clock);
        check({name, " rdy width"}, {31'h0, get_rdy(w8)}, 32'h0);
    endtask

    task automatic add(input bit w8, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] res, input logic exc);
        vec_t v;
        v.w8 = w8; v.op = op; v.a = a; v.b = b; v.res = res; v.exc = exc;
        vecs.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, pulses; logic [31:0] res; logic exc; bit busy_bad;

        add(0, OP_MULT, 32'd7,        32'hFFFFFFFA, 32'hFFFFFFD6, 0);
        add(0, OP_MULT, 32'h00010000, 32'h00010000, 32'h00000000, 1);
        add(0, OP_MULT, 32'h7FFFFFFF, 32'd1,        32'h7FFFFFFF, 0);
        add(0, OP_MULT, 32'hFFFFFFFD, 32'hFFFFFFFB, 32'd15,       0);
        add(0, OP_MULT, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        add(0, OP_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 0);
        add(0, OP_REM,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 0);
        add(0, OP_DIV,  32'd5,        32'd0,        32'd0,        1);
        add(0, OP_REM,  32'd5,        32'd0,        32'd0,        1);
        add(0, OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        add(0, OP_REM,  32'h80000000, 32'hFFFFFFFF, 32'd0,        0);
        add(0, OP_DIV,  32'd100,      32'd7,        32'd14,       0);
        add(0, OP_REM,  32'hFFFFFF9C, 32'd7,        32'hFFFFFFFE, 0);
        add(0, OP_REM,  32'd100,      32'hFFFFFFF9, 32'd2,        0);
        add(1, OP_MULT, 32'hFF,       32'h02,       32'hFE,       1);
        add(1, OP_MULT, 32'h0F,       32'h11,       32'hFF,       0);
        add(1, OP_DIV,  32'd200,      32'd7,        32'd28,       0);
        add(1, OP_REM,  32'd200,      32'd7,        32'd4,        0);
        add(1, OP_DIV,  32'd7,        32'd0,        32'd0,        1);

        reset_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        #12;
        check("reset outputs", {b32.data_result, 29'h0, b32.data_exception,
                                b32.data_resultRDY, b32.data_busy} >> 32, 32'h0);
        check("reset flags", {29'h0, b32.data_exception, b32.data_resultRDY, b32.data_busy}, 32'h0);
        #10 reset_n = 1'b1;
        @(negedge clock);

        foreach (vecs[i]) begin
            run_check($sformatf("vec%0d", i), vecs[i].w8,
                      vecs[i].op == OP_MULT, vecs[i].op == OP_DIV, vecs[i].op == OP_REM,
                      vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].exc);
        end

        // Priority between simultaneous start pulses.
        run_check("prio mult>div", 0, 1, 1, 0, 32'd6, 32'd3, 32'd18, 0);
        run_check("prio div>rem",  0, 0, 1, 1, 32'd7, 32'd2, 32'd3,  0);

        // Abort: DIV at E0, MULT restarts at E10; only the MULT completes.
        pulses = 0; lat = 0; res = '0;
        start_op(0, 0, 1, 0, 32'd100, 32'd7);
        for (int k = 1; k <= 9; k++) begin
            @(posedge clock); @(negedge clock);
            if (b32.data_resultRDY) pulses++;
        end
        start_op(0, 1, 0, 0, 32'd3, 32'd4);
        for (int n = 1; n <= 45; n++) begin
            @(posedge clock); @(negedge clock);
            if (b32.data_resultRDY) begin
                pulses++; lat = n; res = b32.data_result;
            end
        end
        check("abort pulses", pulses, 32'd1);
        check("abort latency", lat, 32'd33);
        check("abort result", res, 32'd12);

        // Start in the RDY cycle: pulse completes, new op runs to completion.
        start_op(0, 1, 0, 0, 32'd5, 32'd5);
        wait_rdy(0, 60, lat, res, exc, busy_bad);
        check("rdy-start first", res, 32'd25);
        start_op(0, 1, 0, 0, 32'd2, 32'd9);
        check("rdy-start rdy low", {31'h0, b32.data_resultRDY}, 32'h0);
        check("rdy-start busy", {31'h0, b32.data_busy}, 32'h1);
        check("rdy-start held", b32.data_result, 32'd25);
        wait_rdy(0, 60, lat, res, exc, busy_bad);
        check("rdy-start latency", lat, 32'd33);
        check("rdy-start result", res, 32'd18);

        // Async reset mid-operation.
        start_op(0, 1, 0, 0, 32'd7, 32'hFFFFFFFA);
        repeat (5) begin @(posedge clock); @(negedge clock); end
        #2 reset_n = 1'b0;
        #1;
        check("async rst result", b32.data_result, 32'h0);
        check("async rst flags", {29'h0, b32.data_exception, b32.data_resultRDY, b32.data_busy}, 32'h0);
        #8 reset_n = 1'b1;
        pulses = 0;
        for (int n = 1; n <= 45; n++) begin
            @(posedge clock); @(negedge clock);
            if (b32.data_resultRDY || b32.data_busy) pulses++;
        end
        check("after rst quiet", pulses, 32'd0);
        run_check("after rst op", 0, 0, 1, 0, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
